// File: rtl/sw_dec_pkg.sv
// Shared definitions for the switch-decoder transmit path.
// Contents:
//   OP_ID_W    - width of the operation tag carried with every request
//   tx_state_e - transmit dispatcher states (idle / issue / stall)
package sw_dec_pkg;

  localparam int OP_ID_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ISSUE = 2'd1,
    TX_STALL = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx_module_if.sv
// Upstream request bus of the transmit dispatcher.
// Signals:
//   req_valid / req_ready        - request handshake (transfer when both high)
//   req_op_id, req_addr, req_wr,
//   req_wdata                    - request payload
//   tx_state                     - dispatcher decision of the previous cycle,
//                                  aligned with the sel_en strobe
// Modports: master (request producer), slave (tx_module).
interface tx_module_if #(
  parameter int A_WIDTH = 8,
  parameter int W_WIDTH = 8
);

  logic                            req_valid;
  logic                            req_ready;
  logic [sw_dec_pkg::OP_ID_W-1:0]  req_op_id;
  logic [A_WIDTH-1:0]              req_addr;
  logic                            req_wr;
  logic [W_WIDTH-1:0]              req_wdata;
  sw_dec_pkg::tx_state_e           tx_state;

  modport master (
    output req_valid, req_op_id, req_addr, req_wr, req_wdata,
    input  req_ready, tx_state
  );

  modport slave (
    input  req_valid, req_op_id, req_addr, req_wr, req_wdata,
    output req_ready, tx_state
  );

endinterface

// File: rtl/tx_req_fifo.sv
// Synchronous request queue (power-of-two depth, >= 2).
// Ports:
//   clk, rst     - clock, synchronous active-high reset (empties the queue)
//   push, din    - write din at the tail (caller guarantees !full)
//   pop, dout    - dout is the head entry; pop removes it (caller guarantees !empty)
//   full, empty  - occupancy flags derived from the registered count
// Push and pop in the same cycle leave the count unchanged.
module tx_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == {(PTR_W+1){1'b0}});
  assign dout  = mem_q[rd_ptr_q];

  // Next-state of storage, pointers (wrap naturally at power-of-two depth) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the queue is empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tx_module.sv
// Transmit dispatcher: queues upstream requests and issues each one to a free
// switch instance with a one-hot, single-cycle sel_en strobe plus payload.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req_if    - request bus (slave modport): valid/ready handshake + payload,
//               tx_state reports the decision that produced the current outputs
//   sw_busy   - per-switch busy from the receive side
//   sel_en    - one-hot dispatch strobe (registered)
//   op_id, addr, wr, wdata - dispatched payload, valid while sel_en != 0,
//               holding its last value otherwise
// Configuration macro: TX_RR_ARB_EN - round-robin switch selection starting
// after the last grant; when undefined, the lowest-index free switch wins.
module tx_module
  import sw_dec_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int A_WIDTH     = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tx_module_if.slave             req_if,
  input  logic [NUM_SW_INST-1:0] sw_busy,
  output logic [NUM_SW_INST-1:0] sel_en,
  output logic [OP_ID_W-1:0]     op_id,
  output logic [A_WIDTH-1:0]     addr,
  output logic                   wr,
  output logic [W_WIDTH-1:0]     wdata
);

  localparam int PL_W = OP_ID_W + A_WIDTH + 1 + W_WIDTH;

  logic                   push_s, pop_s, full_s, empty_s;
  logic [PL_W-1:0]        fifo_din_s, fifo_dout_s;
  logic [NUM_SW_INST-1:0] free_s, grant_s;
  logic                   found_s;
  tx_state_e              state_q, state_d;
  logic [NUM_SW_INST-1:0] pending_q, pending_d;
  logic [NUM_SW_INST-1:0] sel_en_q, sel_en_d;
  logic [OP_ID_W-1:0]     op_id_q, op_id_d;
  logic [A_WIDTH-1:0]     addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [W_WIDTH-1:0]     wdata_q, wdata_d;

  // Ready uses the registered (pre-pop) full flag, so a push never meets a full queue.
  assign req_if.req_ready = ~full_s;
  assign req_if.tx_state  = state_q;
  assign push_s           = req_if.req_valid & ~full_s;
  assign fifo_din_s       = {req_if.req_op_id, req_if.req_addr, req_if.req_wr, req_if.req_wdata};

  tx_req_fifo #(
    .WIDTH (PL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // A switch just granted stays unavailable until its busy flag is seen, which
  // bridges the receive side's one-cycle busy latency.
  assign free_s = ~sw_busy & ~pending_q;

`ifdef TX_RR_ARB_EN
  localparam int LG_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

  logic [LG_W-1:0] last_grant_q, last_grant_d;
  logic [LG_W-1:0] grant_idx_s;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    int idx_v;
    idx_v       = 0;
    grant_s     = '0;
    found_s     = 1'b0;
    grant_idx_s = last_grant_q;
    for (int k = 1; k <= NUM_SW_INST; k++) begin
      idx_v = (int'(last_grant_q) + k) % NUM_SW_INST;
      if (!found_s && free_s[idx_v]) begin
        found_s        = 1'b1;
        grant_s[idx_v] = 1'b1;
        grant_idx_s    = LG_W'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Remember the switch served by the issue decision.
  always_comb begin
    if (pop_s) begin
      last_grant_d = grant_idx_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; reset value makes switch 0 the first candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LG_W'(NUM_SW_INST - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: lowest-index free switch.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (!found_s && free_s[i]) begin
        found_s    = 1'b1;
        grant_s[i] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // Issue decision for the current cycle; ISSUE pops the head into the output registers.
  always_comb begin
    state_d = TX_IDLE;
    pop_s   = 1'b0;
    if (empty_s) begin
      state_d = TX_IDLE;
    end else if (found_s) begin
      state_d = TX_ISSUE;
      pop_s   = 1'b1;
    end else begin
      state_d = TX_STALL;
    end
  end

  // Pending bookkeeping and the registered dispatch outputs.
  always_comb begin
    pending_d = pending_q & ~sw_busy;
    sel_en_d  = '0;
    {op_id_d, addr_d, wr_d, wdata_d} = {op_id_q, addr_q, wr_q, wdata_q};
    if (pop_s) begin
      pending_d = (pending_q & ~sw_busy) | grant_s;
      sel_en_d  = grant_s;
      {op_id_d, addr_d, wr_d, wdata_d} = fifo_dout_s;
    end else begin
      sel_en_d = '0;
    end
  end

  // State, pending and output registers; reset discards in-flight dispatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      pending_q <= '0;
      sel_en_q  <= '0;
      op_id_q   <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_en_q  <= sel_en_d;
      op_id_q   <= op_id_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign sel_en = sel_en_q;
  assign op_id  = op_id_q;
  assign addr   = addr_q;
  assign wr     = wr_q;
  assign wdata  = wdata_q;

endmodule

// File: tb/tb_tx_module.sv
// Self-checking bench for tx_module: a table of requests with expected grants,
// hand-written stall/full/reset/arbitration sequences, and a scoreboard queue
// that is filled when a request is accepted and drained on every sel_en pulse.
module tb_tx_module;
  import sw_dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sw_busy = 5'b00000;
  logic [4:0] sel_en;
  logic [7:0] op_id, addr, wdata;
  logic       wr;

  int errors   = 0;
  int checks   = 0;
  int disp_cnt = 0;

  typedef struct {
    logic [4:0] sel;
    logic [7:0] op;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [4:0] exp_sel;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  tx_module_if #(.A_WIDTH(8), .W_WIDTH(8)) req_if();

  tx_module #(
    .NUM_SW_INST (5),
    .W_WIDTH     (8),
    .A_WIDTH     (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_if  (req_if),
    .sw_busy (sw_busy),
    .sel_en  (sel_en),
    .op_id   (op_id),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every sel_en pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (sel_en !== 5'b00000) begin
      disp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dispatch_unexpected: sel_en=%b op_id=0x%0h, required no dispatch", sel_en, op_id);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sel_en, op_id, addr, wr, wdata} !== {mon_e.sel, mon_e.op, mon_e.addr, mon_e.wr, mon_e.wdata}) begin
          errors++;
          $display("FAIL dispatch: got sel=%b op=%h addr=%h wr=%b wdata=%h, required sel=%b op=%h addr=%h wr=%b wdata=%h",
                   sel_en, op_id, addr, wr, wdata, mon_e.sel, mon_e.op, mon_e.addr, mon_e.wr, mon_e.wdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns one negedge after the request was accepted.
  task automatic drive_req(input logic [7:0] op, input logic [7:0] a, input logic w,
                           input logic [7:0] d, input logic [4:0] exp_sel);
    int n = 0;
    while (req_if.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_if.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got %b, required 1 within 50 cycles", req_if.req_ready);
    end else begin
      req_if.req_valid = 1'b1;
      req_if.req_op_id = op;
      req_if.req_addr  = a;
      req_if.req_wr    = w;
      req_if.req_wdata = d;
      exp_q.push_back('{exp_sel, op, a, w, d});
      @(negedge clk);
      req_if.req_valid = 1'b0;
    end
  endtask

  task automatic wait_disp(input int target, input string name);
    int n = 0;
    while (disp_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, disp_cnt, target);
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1;
    req_if.req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_sel_en"}, sel_en, 0);
    chk({name, "_req_ready"}, req_if.req_ready, 1);
    chk({name, "_state"}, 32'(req_if.tx_state), 32'(TX_IDLE));
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  vec_t       vecs[6];
  logic [4:0] rr_exp[6];

  initial begin
    int base;
    vecs[0] = '{8'h21, 8'h10, 1'b1, 8'h3C, 5'b00001};
    vecs[1] = '{8'h22, 8'hF0, 1'b0, 8'h00, 5'b00010};
    vecs[2] = '{8'h23, 8'h00, 1'b1, 8'hFF, 5'b00100};
    vecs[3] = '{8'h24, 8'h7F, 1'b0, 8'h5A, 5'b01000};
    vecs[4] = '{8'h25, 8'h80, 1'b1, 8'hC3, 5'b10000};
    vecs[5] = '{8'h26, 8'hAA, 1'b1, 8'h69, 5'b00001};
`ifdef TX_RR_ARB_EN
    rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
`else
    rr_exp = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
    req_if.req_valid = 1'b0;
    req_if.req_op_id = 8'h00;
    req_if.req_addr  = 8'h00;
    req_if.req_wr    = 1'b0;
    req_if.req_wdata = 8'h00;

    // Reset state
    apply_reset("rst0");
    chk("rst0_op_id", op_id, 0);
    chk("rst0_addr", addr, 0);
    chk("rst0_wr", wr, 0);
    chk("rst0_wdata", wdata, 0);

    // Single request: push at N, strobe at N+2 for one cycle, payload then holds
    drive_req(8'h11, 8'h20, 1'b1, 8'hA5, 5'b00001);
    chk("single_n1_sel_en", sel_en, 0);
    @(negedge clk);
    chk("single_n2_sel_en", sel_en, 5'b00001);
    chk("single_n2_wdata", wdata, 8'hA5);
    @(negedge clk);
    chk("single_n3_sel_en", sel_en, 0);
    chk("single_hold_op_id", op_id, 8'h11);

    // Table: back-to-back requests, pending guard spreads them, sixth stalls
    apply_reset("rst1");
    base = disp_cnt;
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].op, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].exp_sel);
    end
    @(negedge clk);
    @(negedge clk);
    chk("table_disp_before_ack", disp_cnt - base, 5);
    chk("table_stall_state", 32'(req_if.tx_state), 32'(TX_STALL));
    chk("table_stall_sel_en", sel_en, 0);
    sw_busy = 5'b11111;
    @(negedge clk);
    sw_busy = 5'b00000;
    wait_disp(base + 6, "table_disp_after_ack");
    chk("table_queue_drained", exp_q.size(), 0);

    // Stall: all busy, three queued; freeing switch 3 issues oldest first
    apply_reset("rst2");
    base = disp_cnt;
    sw_busy = 5'b11111;
    drive_req(8'h31, 8'h01, 1'b0, 8'h10, 5'b01000);
    drive_req(8'h32, 8'h02, 1'b1, 8'h20, 5'b01000);
    drive_req(8'h33, 8'h03, 1'b0, 8'h30, 5'b01000);
    repeat (3) @(negedge clk);
    chk("stall_state", 32'(req_if.tx_state), 32'(TX_STALL));
    chk("stall_no_disp", disp_cnt - base, 0);
    for (int k = 0; k < 3; k++) begin
      sw_busy = 5'b10111;
      wait_disp(base + k + 1, "stall_release");
      sw_busy = 5'b11111;
      @(negedge clk);
    end

    // Full: four queued with all busy, one pop reopens req_ready
    apply_reset("rst3");
    sw_busy = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      drive_req(8'h41 + 8'(k), 8'h40, 1'b1, 8'h90 + 8'(k), 5'b00100);
    end
    chk("full_ready_low", req_if.req_ready, 0);
    @(negedge clk);
    chk("full_ready_still_low", req_if.req_ready, 0);
    sw_busy = 5'b11011;
    @(negedge clk);
    chk("full_pop_sel_en", sel_en, 5'b00100);
    chk("full_ready_after_pop", req_if.req_ready, 1);
    sw_busy = 5'b11111;
    @(negedge clk);
    drive_req(8'h45, 8'h41, 1'b0, 8'h95, 5'b00100);
    chk("full_ready_refill", req_if.req_ready, 0);
    apply_reset("rst_full");

    // Reset mid-operation discards queued requests
    base = disp_cnt;
    sw_busy = 5'b11111;
    drive_req(8'h51, 8'h05, 1'b1, 8'h01, 5'b00001);
    drive_req(8'h52, 8'h06, 1'b1, 8'h02, 5'b00001);
    sw_busy = 5'b00000;
    apply_reset("rst_mid");
    repeat (6) @(negedge clk);
    chk("rst_mid_no_dispatch", disp_cnt - base, 0);

    // Arbitration with each grant acknowledged by a busy pulse
    base = disp_cnt;
    for (int k = 0; k < 6; k++) begin
      drive_req(8'h60 + 8'(k), 8'(k), k[0], ~8'(k), rr_exp[k]);
      wait_disp(base + k + 1, "arb_disp");
      sw_busy = rr_exp[k];
      @(negedge clk);
      sw_busy = 5'b00000;
      @(negedge clk);
    end
    chk("arb_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
